// File: rtl/mem_stage_lsu.sv
// MEM stage of the RV32I pipeline: loads/stores against a word-organised data memory.
// Optional MEM_WAIT_STATE_EN adds an LD_HOLD state that stretches load latency by WAIT_STATES.
module mem_stage_lsu #(
    parameter int DBITS          = 32,
    parameter int REGNOBITS      = 5,
    parameter int DMEM_ADDR_BITS = 10,
    parameter int WAIT_STATES    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_in,
    input  logic                 is_load_in,
    input  logic                 is_store_in,
    input  logic [2:0]           funct3_in,
    input  logic [DBITS-1:0]     addr_in,
    input  logic [DBITS-1:0]     sdata_in,
    input  logic [DBITS-1:0]     aluout_in,
    input  logic [REGNOBITS-1:0] rd_in,
    input  logic                 wr_reg_in,
    input  logic [DBITS-1:0]     pc_in,
    input  logic [DBITS-1:0]     inst_in,
    output logic                 stall_out,
    output logic                 valid_out,
    output logic [DBITS-1:0]     regval_out,
    output logic [REGNOBITS-1:0] rd_out,
    output logic                 wr_reg_out,
    output logic                 fault_out,
    output logic [DBITS-1:0]     pc_out,
    output logic [DBITS-1:0]     inst_out,
    output logic [1:0]           state_dbg
);
    // Handshake: an instruction is taken on any edge where valid_in && !stall_out;
    // while stall_out is high the AGEX latch must be held and valid_in is ignored.

    localparam int DWORDS = 1 << DMEM_ADDR_BITS;

`ifdef MEM_WAIT_STATE_EN
    typedef enum logic [1:0] {IDLE = 2'd0, LD_WAIT = 2'd1, LD_HOLD = 2'd2} state_t;
    localparam int CNTW = (WAIT_STATES > 2) ? $clog2(WAIT_STATES) : 1;
    logic [CNTW-1:0] cnt;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, LD_WAIT = 2'd1} state_t;
`endif

    state_t state, state_nxt;

    logic [DBITS-1:0]          mem [DWORDS];
    logic [DBITS-1:0]          rdata, shifted, ld_val, wdata;
    logic [DMEM_ADDR_BITS-1:0] widx;
    logic [1:0]                off;
    logic [3:0]                be;
    logic                      accept, misaligned, ld_bad, st_bad, fault;
    logic                      do_load, do_store, load_done;
    logic [2:0]                lat_f3;
    logic [1:0]                lat_off;
    logic [REGNOBITS-1:0]      lat_rd;
    logic                      lat_wr;
    logic [DBITS-1:0]          lat_pc, lat_inst;
    logic [7:0]                lbyte;
    logic [15:0]               lhalf;
    logic                      unused_bits;

    assign unused_bits = ^{addr_in[DBITS-1:DMEM_ADDR_BITS+2], (WAIT_STATES != 0)};
    assign stall_out   = (state != IDLE);
    assign state_dbg   = state;

    always_comb begin
        widx       = addr_in[DMEM_ADDR_BITS+1:2];
        off        = addr_in[1:0];
        accept     = valid_in && !stall_out;
        misaligned = (funct3_in[1:0] == 2'b01 && off[0]) || (funct3_in[1:0] == 2'b10 && off != 2'b00);
        ld_bad     = (funct3_in[1:0] == 2'b11) || (funct3_in[2] && funct3_in[1]);
        st_bad     = funct3_in[2] || (funct3_in[1:0] == 2'b11);
        fault      = (is_load_in && is_store_in)
                  || (is_load_in && (ld_bad || misaligned))
                  || (is_store_in && (st_bad || misaligned));
        do_load    = accept && is_load_in && !fault;
        do_store   = accept && is_store_in && !fault && !reset;
        be         = 4'b1111;
        wdata      = sdata_in;
        case (funct3_in[1:0])
            2'b00: begin
                be    = 4'b0001 << off;
                wdata = {4{sdata_in[7:0]}};
            end
            2'b01: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{sdata_in[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        load_done = 1'b0;
        case (state)
            IDLE: if (do_load) state_nxt = LD_WAIT;
`ifdef MEM_WAIT_STATE_EN
            LD_WAIT: begin
                if (WAIT_STATES == 0) begin
                    load_done = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = LD_HOLD;
                end
            end
            LD_HOLD: begin
                if (cnt == '0) begin
                    load_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
`else
            LD_WAIT: begin
                load_done = 1'b1;
                state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

`ifdef MEM_WAIT_STATE_EN
    // Counter holds the remaining LD_HOLD cycles minus one; capture happens when it is zero.
    always_ff @(posedge clk) begin
        if (reset)                                cnt <= '0;
        else if (state == LD_WAIT)                cnt <= CNTW'(WAIT_STATES - 1);
        else if (state == LD_HOLD && cnt != '0)   cnt <= cnt - CNTW'(1);
    end
`endif

    // Memory is never reset; contents survive a pipeline reset.
    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (do_load) rdata <= mem[widx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_f3   <= '0;
            lat_off  <= '0;
            lat_rd   <= '0;
            lat_wr   <= 1'b0;
            lat_pc   <= '0;
            lat_inst <= '0;
        end else if (do_load) begin
            lat_f3   <= funct3_in;
            lat_off  <= off;
            lat_rd   <= rd_in;
            lat_wr   <= wr_reg_in;
            lat_pc   <= pc_in;
            lat_inst <= inst_in;
        end
    end

    always_comb begin
        shifted = rdata >> {lat_off, 3'b000};
        lbyte   = shifted[7:0];
        lhalf   = lat_off[1] ? rdata[31:16] : rdata[15:0];
        case (lat_f3)
            3'b000:  ld_val = {{24{lbyte[7]}}, lbyte};
            3'b001:  ld_val = {{16{lhalf[15]}}, lhalf};
            3'b100:  ld_val = {24'b0, lbyte};
            3'b101:  ld_val = {16'b0, lhalf};
            default: ld_val = rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out  <= 1'b0;
            regval_out <= '0;
            rd_out     <= '0;
            wr_reg_out <= 1'b0;
            fault_out  <= 1'b0;
            pc_out     <= '0;
            inst_out   <= '0;
        end else if (load_done) begin
            valid_out  <= 1'b1;
            regval_out <= ld_val;
            rd_out     <= lat_rd;
            wr_reg_out <= lat_wr && (lat_rd != '0);
            fault_out  <= 1'b0;
            pc_out     <= lat_pc;
            inst_out   <= lat_inst;
        end else if (accept && (fault || !is_load_in)) begin
            valid_out <= 1'b1;
            rd_out    <= rd_in;
            pc_out    <= pc_in;
            inst_out  <= inst_in;
            fault_out <= fault;
            if (fault || is_store_in) begin
                regval_out <= '0;
                wr_reg_out <= 1'b0;
            end else begin
                regval_out <= aluout_in;
                wr_reg_out <= wr_reg_in && (rd_in != '0);
            end
        end else begin
            // Bubble, including the edge that launches a load.
            valid_out  <= 1'b0;
            wr_reg_out <= 1'b0;
            fault_out  <= 1'b0;
        end
    end

endmodule
